// File: rtl/switches_reader_pkg.sv
// Shared go-board constants for the push-button reader.
package switches_reader_pkg;
    localparam int NUM_CH           = 4;
    localparam int DEBOUNCE_DEFAULT = 250000;  // 10 ms at 25 MHz
endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-FF synchronizer, stability counter, debounced level, press strobe.
// LEVEL changes DEBOUNCE_CYCLES+2 edges after a clean input edge; no backpressure.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic sw_raw,
    output logic level,
    output logic press,
    output logic press_next
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    always_comb begin
        sync1_d    = sw_raw;
        sync2_d    = sync1_q;
        cnt_d      = '0;
        level_d    = level_q;
        press_next = 1'b0;
        // The accept happens on the edge where the count would hit DEBOUNCE_CYCLES.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d    = ~level_q;
                press_next = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = press_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
endmodule

// File: rtl/switches_reader.sv
// Four debounced push-buttons with one-cycle press strobes and per-button LED toggles.
// Strobe/toggle land DEBOUNCE_CYCLES+2 edges after a clean press; no backpressure.
module switches_reader
    import switches_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       SW1,
    input  logic       SW2,
    input  logic       SW3,
    input  logic       SW4,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3,
    output logic       LED4,
    output logic [3:0] PRESS,
    output logic [3:0] LEVEL
);
    logic [NUM_CH-1:0] sw_raw;
    logic [NUM_CH-1:0] press_next;
    logic [NUM_CH-1:0] led_q, led_d;

    assign sw_raw = {SW4, SW3, SW2, SW1};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rstn      (rstn),
            .sw_raw    (sw_raw[i]),
            .level     (LEVEL[i]),
            .press     (PRESS[i]),
            .press_next(press_next[i])
        );
    end

    // Toggle off the pre-register strobe so LED flips on the same edge PRESS rises.
    always_comb begin
        led_d = led_q ^ press_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign {LED4, LED3, LED2, LED1} = led_q;
endmodule
